// File: rtl/sdram_burst_responder_pkg.sv
// Shared constants and state type for the SDRAM burst-read responder and the
// video controller's read port.
package sdram_burst_responder_pkg;

    localparam int SDRAM_BURST_LEN  = 64;
    localparam int SDRAM_BURST_BITS = $clog2(SDRAM_BURST_LEN);
    localparam int SDRAM_ADDR_W     = 24;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        STREAM,
        WAIT_ACK
    } sdram_resp_state_t;

endpackage

// File: rtl/sdram_burst_responder_fifo.sv
// First-word-fall-through synchronous FIFO; the head word is readable the
// cycle after it is pushed. Pointers wrap modulo DEPTH (power of two).
module sync_fifo_fwft
    import sdram_burst_responder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = SDRAM_BURST_LEN
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sdram_burst_responder.sv
// Responder for the video burst-read handshake: one aligned SDRAM burst per
// request, buffered and streamed out. Optional checker: SDRAM_RESP_PROTOCOL_CHECK_EN.
module sdram_burst_responder
    import sdram_burst_responder_pkg::*;
#(
    parameter int BURST_LEN   = SDRAM_BURST_LEN,
    parameter int START_DELAY = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_rd_i,
    input  logic [SDRAM_ADDR_W-1:0] req_addr_x16_i,
    input  logic                    req_ack_i,
    output logic                    req_rdy_o,
    output logic                    req_resp_valid_o,
    output logic [15:0]             req_rdata_o,
    output logic                    mem_cmd_valid_o,
    input  logic                    mem_cmd_ready_i,
    output logic [SDRAM_ADDR_W-1:0] mem_addr_x16_o,
    input  logic                    mem_rvalid_i,
    input  logic [15:0]             mem_rdata_i,
    output logic                    err_o
);

    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam int DLY_W = (START_DELAY > 2) ? $clog2(START_DELAY) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BURST_LEN);

    sdram_resp_state_t       state_q, state_d;
    logic [SDRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [DLY_W-1:0]        dly_q, dly_d;
    logic [CNT_W-1:0]        rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0]        tx_cnt_q, tx_cnt_d;
    logic                    abort_q, abort_d;
    logic                    rdy;
    logic                    push;
    logic                    flush;
    logic                    fifo_empty;
    logic [15:0]             fifo_head;

    sync_fifo_fwft #(
        .WIDTH (16),
        .DEPTH (BURST_LEN)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i (mem_rdata_i),
        .pop_i   (rdy),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        dly_d    = dly_q;
        rx_cnt_d = rx_cnt_q;
        tx_cnt_d = tx_cnt_q;
        abort_d  = abort_q;
        rdy      = 1'b0;
        push     = 1'b0;
        flush    = 1'b0;
        if (dly_q != '0) dly_d = dly_q - 1'b1;
        case (state_q)
            IDLE: begin
                if (req_rd_i) begin
                    addr_d   = req_addr_x16_i;
                    dly_d    = DLY_W'(START_DELAY - 1);
                    rx_cnt_d = '0;
                    tx_cnt_d = '0;
                    abort_d  = 1'b0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_cmd_ready_i) state_d = STREAM;
            end
            STREAM: begin
                push = mem_rvalid_i;
                if (push) rx_cnt_d = rx_cnt_q + 1'b1;
                // Once rd drops, stop streaming but drain the core's full burst before idling.
                if (abort_q || !req_rd_i) begin
                    abort_d = 1'b1;
                    if (rx_cnt_d == FULL_CNT) begin
                        flush   = 1'b1;
                        abort_d = 1'b0;
                        state_d = IDLE;
                    end
                end else if (!fifo_empty && dly_q == '0 && tx_cnt_q < FULL_CNT) begin
                    rdy      = 1'b1;
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    if (tx_cnt_d == FULL_CNT) state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (req_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            dly_q    <= '0;
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            dly_q    <= dly_d;
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
            abort_q  <= abort_d;
        end
    end

    assign req_rdy_o        = rdy;
    assign req_resp_valid_o = rdy;
    assign req_rdata_o      = rdy ? fifo_head : '0;
    assign mem_cmd_valid_o  = (state_q == ISSUE);
    assign mem_addr_x16_o   = addr_q;

`ifdef SDRAM_RESP_PROTOCOL_CHECK_EN
    logic err_q;
    logic viol_rd;
    logic viol_addr;
    logic viol_ack;

    assign viol_rd   = (state_q == STREAM) && !abort_q && !req_rd_i;
    assign viol_addr = (state_q == IDLE) && req_rd_i &&
                       (req_addr_x16_i[$clog2(BURST_LEN)-1:0] != '0);
    assign viol_ack  = req_ack_i && (state_q != WAIT_ACK);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (viol_rd || viol_addr || viol_ack) begin
            err_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!viol_rd)   else $warning("rd dropped before burst end");
            assert (!viol_addr) else $warning("misaligned burst address");
            assert (!viol_ack)  else $warning("ack outside WAIT_ACK");
        end
    end
`endif

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: doc/sdram_burst_responder.md
# sdram_burst_responder

Responder end of the video burst-read handshake (`rd`/`rdy`/`ack`/`resp_valid`). It sits between the video controller's SDRAM read port and the SDRAM core's command/read-data interface. On each request it issues one aligned burst read to the core and buffers the returned words in a FIFO. It then streams the words to the requester, one per `rdy` cycle, honouring the requester's fixed wait-state window.

## Interface
Parameters:
- `BURST_LEN`, 64: words per burst; power of two.
- `START_DELAY`, 3: minimum cycles from the first cycle `req_rd_i` is sampled high to the first `req_rdy_o`.

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset. One clock; reset is synchronous and active-high.
- `req_rd_i`  in  1  read request level; held high until the last word of the burst.
- `req_addr_x16_i`  in  24  burst start address in 16-bit words; must be `BURST_LEN`-aligned.
- `req_ack_i`  in  1  one-cycle burst completion strobe from the requester.
- `req_rdy_o`  out  1  word presented and consumed this cycle.
- `req_resp_valid_o`  out  1  one-cycle response strobe; always identical to `req_rdy_o`.
- `req_rdata_o`  out  16  data word; valid while `req_rdy_o` is high.
- `mem_cmd_valid_o`  out  1  burst read command valid.
- `mem_cmd_ready_i`  in  1  core accepts the command.
- `mem_addr_x16_o`  out  24  command address.
- `mem_rvalid_i`  in  1  read-data word valid. Exactly `BURST_LEN` words arrive per command, with arbitrary gaps.
- `mem_rdata_i`  in  16  read data.
- `err_o`  out  1  sticky protocol error.

## Operation
- State machine states: IDLE, ISSUE, STREAM, WAIT_ACK.
- **IDLE**
  - On `req_rd_i`=1: latch `req_addr_x16_i` into `mem_addr_x16_o`.
  - Load the delay counter with `START_DELAY`-1.
  - Clear the counters `rx_cnt` and `tx_cnt`.
  - Go to ISSUE.
- **ISSUE**
  - Hold `mem_cmd_valid_o`=1 with a stable address.
  - On `mem_cmd_ready_i`: drop valid and go to STREAM.
- **STREAM**
  - Each `mem_rvalid_i` pushes `mem_rdata_i` into the FIFO (depth `BURST_LEN`, first-word-fall-through) and increments `rx_cnt`.
  - `req_rdy_o` is asserted when all of these hold:
    - FIFO non-empty;
    - delay counter = 0;
    - `req_rd_i`=1;
    - `tx_cnt` < `BURST_LEN`.
  - Each `rdy` cycle pops the FIFO and increments `tx_cnt`.
  - When `tx_cnt` reaches `BURST_LEN`, go to WAIT_ACK.
- **WAIT_ACK**
  - On `req_ack_i`: go to IDLE.
  - The requester raises `rd` for the next burst no earlier than the cycle after `ack`. IDLE therefore accepts it on that cycle.
- The delay counter decrements to 0 from entry to ISSUE, independent of memory progress.
- Counters are `$clog2(BURST_LEN)+1` bits wide. The FIFO pointers wrap modulo `BURST_LEN`.

Boundary conditions:
- Push and pop in the same cycle: FIFO count unchanged.
- Overflow is impossible by construction. Depth = `BURST_LEN` and one command is outstanding at a time.
- `req_rd_i` drops in STREAM before `tx_cnt` = `BURST_LEN` (violation):
  - stop asserting `rdy`;
  - keep absorbing words until `rx_cnt` = `BURST_LEN`;
  - flush the FIFO and go to IDLE.
- `req_ack_i` outside WAIT_ACK is ignored.
- A misaligned address is passed through unmodified (violation).
- Reset mid-operation: state goes to IDLE and the FIFO is emptied. The SDRAM core shares `rst_i`, so no words are in flight after reset.

Reset values: `req_rdy_o`=0, `req_resp_valid_o`=0, `req_rdata_o`=0, `mem_cmd_valid_o`=0, `mem_addr_x16_o`=0, `err_o`=0.

## Timing
- The first `rdy` comes no earlier than `START_DELAY` cycles after `rd` is first sampled high. It is later if memory data has not arrived.
- Throughput: one word per cycle once the FIFO holds data. A burst fully prefetched before the delay expires streams as `BURST_LEN` contiguous `rdy` cycles.
- FIFO head to `req_rdata_o`: registered, 0 extra cycles. A word pushed at edge N is presentable from cycle N+1.
- `req_resp_valid_o` equals `req_rdy_o` every cycle. The requester relies on this equality to drop its handshake.
- Minimum request-to-request turnaround: `ack` cycle + 1.

## Configuration
- `SDRAM_RESP_PROTOCOL_CHECK_EN` defined:
  - `err_o` sets on `rd` dropped mid-STREAM, address low bits ≠ 0, or `ack` outside WAIT_ACK;
  - `err_o` is cleared only by reset;
  - simulation assertions fire on each of these conditions.
- Undefined: `err_o` is tied 0 and the checker logic is not compiled.

## Structure
- Shared package holds:
  - `BURST_LEN`/`BURST_BITS` defaults, shared with the video controller;
  - the state enum `sdram_resp_state_t`;
  - the word-address width constant (24).
- One sub-module: `sync_fifo_fwft`, parameterised width 16 and depth `BURST_LEN`, with synchronous active-high reset.

## Test plan
- **Single burst, no gaps:** `rd`=1, addr 0x800000; memory returns 64 words 0x0000..0x003F back-to-back after a 2-cycle `cmd_ready` delay → first `rdy` ≥3 cycles after `rd`; 64 consecutive `rdy` cycles with data 0x0000..0x003F; `ack` → IDLE.
- **Gappy memory:** `rvalid` every 3rd cycle → `rdy` only when data is available; order preserved; exactly 64 `rdy` strobes; `resp_valid` == `rdy` every cycle.
- **Back-to-back bursts:** five bursts at addresses 0x800000, 0x800040, … 0x800100 (one 320-word line) → five `mem` commands with the same addresses; `rd` raised the cycle after each `ack` is accepted.
- **Immediate prefetch:** memory delivers all words before `START_DELAY` expires → first `rdy` exactly 3 cycles after `rd` is sampled; no FIFO overflow.
- **Mid-burst reset:** assert `rst_i` after word 20 → all outputs at reset values next cycle; FIFO empty; a fresh request completes normally.
- **Protocol violation (macro on):** drop `rd` after 10 words → `err_o`=1 sticky; FSM absorbs the remaining words and returns to IDLE.
